// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave: word length macro, state encoding and
// default synchronizer depth.
`ifndef SPI_DATA_WIDTH
`define SPI_DATA_WIDTH 8
`endif

package spi_slave_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_e;

    localparam int SPI_DATA_WIDTH_DEF  = `SPI_DATA_WIDTH;
    localparam int SPI_SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spi_slave_sync.sv
// Multi-flop synchronizer bringing an asynchronous SPI pin into the clk domain.
module spi_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = din;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode 0 slave, MSB first, with a one-entry TX holding buffer and
// back-to-back word support inside one chip-select frame.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = `SPI_DATA_WIDTH,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_underrun,
    output logic                  frame_abort,
    output logic                  busy,
    output spi_state_e            state_dbg
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic sclk_s, cs_s, mosi_s;

    spi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk), .dout(sclk_s));
    spi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n), .dout(cs_s));
    spi_sync #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi), .dout(mosi_s));

    spi_state_e            state_q, state_d;
    logic                  sclk_prev_q, cs_prev_q;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d, cnt_inc;
    logic                  reload_q, reload_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_word;
    logic [DATA_WIDTH-1:0] buf_q, buf_d, rx_data_q, rx_data_d;
    logic                  buf_full_q, buf_full_d, miso_oe_q, miso_oe_d;
    logic                  rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
    logic                  frame_abort_q, frame_abort_d;
    logic                  sclk_rise, sclk_fall, cs_rise, cs_fall, load;

    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cnt_inc   = bit_cnt_q + 1'b1;
    assign rx_word   = {rx_sr_q[DATA_WIDTH-2:0], mosi_s};

    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        reload_d      = reload_q;
        tx_sr_d       = tx_sr_q;
        rx_sr_d       = rx_sr_q;
        buf_d         = buf_q;
        buf_full_d    = buf_full_q;
        miso_oe_d     = miso_oe_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    load      = 1'b1;
                    miso_oe_d = 1'b1;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                    rx_sr_d   = '0;
                end
            end
            ST_ACTIVE: begin
                // Chip-select release wins over any sclk edge seen in the same cycle.
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    miso_oe_d     = 1'b0;
                    bit_cnt_d     = '0;
                    reload_d      = 1'b0;
                    rx_sr_d       = '0;
                    frame_abort_d = (bit_cnt_q != '0);
                end else if (sclk_rise) begin
                    rx_sr_d = rx_word;
                    if (cnt_inc == CNT_W'(DATA_WIDTH)) begin
                        rx_data_d  = rx_word;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        reload_d   = 1'b1;
                    end else begin
                        bit_cnt_d = cnt_inc;
                    end
                end else if (sclk_fall) begin
                    if (reload_q) begin
                        load     = 1'b1;
                        reload_d = 1'b0;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) begin
            if (buf_full_q) begin
                tx_sr_d    = buf_q;
                buf_full_d = 1'b0;
            end else begin
                tx_sr_d       = '0;
                tx_underrun_d = 1'b1;
            end
        end
        // A write only happens when the buffer was empty, so it never races a load that drains it.
        if (tx_valid && !buf_full_q) begin
            buf_d      = tx_data;
            buf_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sclk_prev_q   <= 1'b0;
            cs_prev_q     <= 1'b1;
            bit_cnt_q     <= '0;
            reload_q      <= 1'b0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            buf_q         <= '0;
            buf_full_q    <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_prev_q   <= sclk_s;
            cs_prev_q     <= cs_s;
            bit_cnt_q     <= bit_cnt_d;
            reload_q      <= reload_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            buf_q         <= buf_d;
            buf_full_q    <= buf_full_d;
            miso_oe_q     <= miso_oe_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_oe_q & tx_sr_q[DATA_WIDTH-1];
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~buf_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q == ST_ACTIVE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-banged mode 0 master plus pulse monitors.
module tb_spi_slave;
    import spi_slave_pkg::*;

    logic       clk, rst_n, sclk, cs_n, mosi;
    logic       miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_underrun, frame_abort, busy;
    logic [7:0] tx_data, rx_data;
    spi_state_e state_dbg;

    int total = 0;
    int bad   = 0;
    int rx_cnt = 0, ur_cnt = 0, ab_cnt = 0;
    logic [7:0] rx_log[$];

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_underrun(tx_underrun), .frame_abort(frame_abort), .busy(busy),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                rx_cnt = rx_cnt + 1;
                rx_log.push_back(rx_data);
            end
            if (tx_underrun) ur_cnt = ur_cnt + 1;
            if (frame_abort) ab_cnt = ab_cnt + 1;
        end
    end

    task automatic half();
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // One word; on the last word the final sclk fall and the cs_n rise coincide.
    task automatic xfer(input logic [7:0] mo, input bit last, output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            half();
            sclk = 1'b1;
            mi[i] = miso;
            half();
            sclk = 1'b0;
            if (i == 0 && last) cs_n = 1'b1;
        end
        if (last) repeat (12) @(negedge clk);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            total++; bad++;
            $display("FAIL %s: tx_ready timeout, got 0 want 1", name);
        end
    endtask

    task automatic push(input logic [7:0] d);
        wait_ready("push");
        @(negedge clk);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (miso !== 1'b0)    begin bad++; $display("FAIL reset_miso: got %b want 0", miso); end
        total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", miso_oe); end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if ({rx_valid, tx_underrun, frame_abort} !== 3'b000) begin
            bad++; $display("FAIL reset_pulses: got %b want 000", {rx_valid, tx_underrun, frame_abort});
        end
    endtask

    task automatic test_single();
        int r0 = rx_cnt, u0 = ur_cnt;
        logic [7:0] mi;
        push(8'hA5);
        cs_low();
        xfer(8'h3C, 1'b1, mi);
        total++; if (mi !== 8'hA5) begin bad++; $display("FAIL single_miso: got %h want a5", mi); end
        total++; if (rx_data !== 8'h3C) begin bad++; $display("FAIL single_rx_data: got %h want 3c", rx_data); end
        total++; if (rx_cnt - r0 !== 1) begin bad++; $display("FAIL single_rx_count: got %0d want 1", rx_cnt - r0); end
        total++; if (ur_cnt - u0 !== 0) begin bad++; $display("FAIL single_underrun: got %0d want 0", ur_cnt - u0); end
    endtask

    task automatic test_back_to_back();
        int r0 = rx_cnt;
        logic [7:0] m0, m1, m2;
        logic [7:0] exp_tx [3] = '{8'h11, 8'h22, 8'h33};
        push(8'h11);
        fork
            begin
                cs_low();
                xfer(8'h01, 1'b0, m0);
                xfer(8'h02, 1'b0, m1);
                xfer(8'h03, 1'b1, m2);
            end
            begin
                for (int k = 1; k < 3; k++) begin
                    wait_ready("refill");
                    @(negedge clk);
                    tx_data = exp_tx[k]; tx_valid = 1'b1;
                    @(negedge clk);
                    tx_valid = 1'b0;
                end
            end
        join
        total++; if ({m0, m1, m2} !== 24'h112233) begin bad++; $display("FAIL b2b_miso: got %h want 112233", {m0, m1, m2}); end
        total++; if (rx_cnt - r0 !== 3) begin bad++; $display("FAIL b2b_rx_count: got %0d want 3", rx_cnt - r0); end
        for (int k = 0; k < 3; k++) begin
            if (rx_cnt - r0 > k) begin
                total++;
                if (rx_log[r0 + k] !== 8'(k + 1)) begin
                    bad++; $display("FAIL b2b_rx_word%0d: got %h want %h", k, rx_log[r0 + k], 8'(k + 1));
                end
            end
        end
    endtask

    task automatic test_underrun();
        int u0 = ur_cnt;
        logic [7:0] mi;
        cs_low();
        total++; if (ur_cnt - u0 !== 1) begin bad++; $display("FAIL underrun_at_cs: got %0d want 1", ur_cnt - u0); end
        xfer(8'hFF, 1'b1, mi);
        total++; if (mi !== 8'h00) begin bad++; $display("FAIL underrun_miso: got %h want 00", mi); end
        total++; if (ur_cnt - u0 !== 1) begin bad++; $display("FAIL underrun_count: got %0d want 1", ur_cnt - u0); end
        total++; if (rx_data !== 8'hFF) begin bad++; $display("FAIL underrun_rx_data: got %h want ff", rx_data); end
    endtask

    task automatic test_abort();
        int r0 = rx_cnt, a0 = ab_cnt;
        logic [7:0] mi;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            mosi = i[0];
            half(); sclk = 1'b1; half(); sclk = 1'b0;
        end
        half();
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        total++; if (ab_cnt - a0 !== 1) begin bad++; $display("FAIL abort_pulse: got %0d want 1", ab_cnt - a0); end
        total++; if (rx_cnt - r0 !== 0) begin bad++; $display("FAIL abort_no_rx: got %0d want 0", rx_cnt - r0); end
        total++; if ({busy, miso_oe} !== 2'b00) begin bad++; $display("FAIL abort_idle: got %b want 00", {busy, miso_oe}); end
        cs_low();
        xfer(8'h5A, 1'b1, mi);
        total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL abort_next_rx: got %h want 5a", rx_data); end
        total++; if (rx_cnt - r0 !== 1) begin bad++; $display("FAIL abort_next_count: got %0d want 1", rx_cnt - r0); end
    endtask

    task automatic test_buffer();
        int u0;
        bit rdy_seen = 1'b0;
        logic [7:0] mi;
        push(8'h77);
        @(negedge clk);
        tx_data = 8'h99; tx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (tx_ready) rdy_seen = 1'b1;
        end
        tx_valid = 1'b0;
        total++; if (rdy_seen) begin bad++; $display("FAIL full_ready: got 1 want 0"); end
        cs_low();
        xfer(8'h00, 1'b1, mi);
        total++; if (mi !== 8'h77) begin bad++; $display("FAIL full_not_overwritten: got %h want 77", mi); end
        // Write lands on the third clock edge after cs_n falls, the same edge as the entry load.
        u0 = ur_cnt;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tx_data = 8'hC3; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        total++; if (ur_cnt - u0 !== 1) begin bad++; $display("FAIL same_cycle_underrun: got %0d want 1", ur_cnt - u0); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL same_cycle_held: got %b want 0", tx_ready); end
        xfer(8'h12, 1'b1, mi);
        total++; if (mi !== 8'h00) begin bad++; $display("FAIL same_cycle_miso: got %h want 00", mi); end
        cs_low();
        xfer(8'h34, 1'b1, mi);
        total++; if (mi !== 8'hC3) begin bad++; $display("FAIL same_cycle_next: got %h want c3", mi); end
    endtask

    task automatic test_reset_mid();
        int r0 = rx_cnt, a0 = ab_cnt;
        push(8'hE7);
        cs_low();
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            half(); sclk = 1'b1; half(); sclk = 1'b0;
        end
        half(); sclk = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if ({miso, miso_oe, busy} !== 3'b000) begin
            bad++; $display("FAIL midrst_outputs: got %b want 000", {miso, miso_oe, busy});
        end
        total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midrst_rx_data: got %h want 00", rx_data); end
        total++; if ({rx_valid, tx_underrun, frame_abort} !== 3'b000) begin
            bad++; $display("FAIL midrst_pulses: got %b want 000", {rx_valid, tx_underrun, frame_abort});
        end
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++; if ((rx_cnt - r0) + (ab_cnt - a0) !== 0) begin
            bad++; $display("FAIL midrst_no_pulse: got rx=%0d abort=%0d want 0", rx_cnt - r0, ab_cnt - a0);
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_buffer();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
